// File: rtl/hk_spi_responder.sv
// Housekeeping SPI responder.
// Oversamples the pad-side SCK/CSB/SDI pins into the core clock domain and
// decodes command / address / data bytes into single-cycle register read and
// write strobes. Read data is shifted out MSB first on SDO.
module hk_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       spi_sck,
    input  logic       spi_csb,
    input  logic       spi_sdi,
    output logic       spi_sdo,
    output logic       spi_sdo_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        COMMAND,
        ADDRESS,
        DATA,
        IGNORE
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sck_sync, csb_sync, sdi_sync;
    logic       sck_s, csb_s, sdi_s, sck_d;
    logic       sck_rise, sck_fall;
    logic       armed;        // CSB has been seen high since reset
    logic [2:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] out_shift;
    logic [1:0] mode;         // [1] = write, [0] = read
    logic       counted;      // command gave a non-zero byte count
    logic [2:0] byte_cnt;
    logic       byte_done;    // one cycle after a data byte completes
    logic       rd_req;       // issue reg_re on the next cycle
    logic       re_d;         // reg_rdata is valid this cycle
    logic [7:0] byte_in;
    logic       byte_end, load_cmd, load_addr, data_end;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign csb_s    = csb_sync[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign busy     = (state != IDLE);

    // Synchronizer chains and the previous-SCK sample for edge detection.
    // The CSB chain clears to 0 so a CSB held low across reset never looks
    // like a fresh falling edge; arming requires a real high sample.
    // NOTE: clocked state always uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sck_sync <= '0;
            csb_sync <= '0;
            sdi_sync <= '0;
            sck_d    <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            csb_sync <= {csb_sync[SYNC_STAGES-2:0], spi_csb};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            sck_d    <= sck_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // Next-state decode and byte-boundary events.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n   = state;
        byte_in   = {shift_in[6:0], sdi_s};
        byte_end  = sck_rise && (bit_cnt == 3'd7) && !csb_s;
        load_cmd  = 1'b0;
        load_addr = 1'b0;
        data_end  = 1'b0;
        if (csb_s) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (armed) state_n = COMMAND;
                COMMAND: if (byte_end) begin
                    load_cmd = 1'b1;
                    state_n  = (byte_in[7:6] == 2'b00) ? IGNORE : ADDRESS;
                end
                ADDRESS: if (byte_end) begin
                    load_addr = 1'b1;
                    state_n   = DATA;
                end
                DATA: begin
                    data_end = byte_end;
                    if (byte_done && counted && (byte_cnt == 3'd1)) state_n = IGNORE;
                end
                IGNORE:  state_n = IGNORE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Datapath: bit shifting, address/count tracking, strobes and SDO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed      <= 1'b0;
            bit_cnt    <= '0;
            shift_in   <= '0;
            out_shift  <= '0;
            mode       <= '0;
            counted    <= 1'b0;
            byte_cnt   <= '0;
            byte_done  <= 1'b0;
            rd_req     <= 1'b0;
            re_d       <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            spi_sdo    <= 1'b0;
            spi_sdo_oe <= 1'b0;
        end else begin
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            byte_done <= 1'b0;
            rd_req    <= 1'b0;
            re_d      <= reg_re;

            if (csb_s) armed <= 1'b1;

            if (state == IDLE) begin
                bit_cnt  <= '0;
                shift_in <= '0;
            end else if (sck_rise) begin
                bit_cnt  <= bit_cnt + 3'd1;
                shift_in <= byte_in;
            end

            if (load_cmd) begin
                mode     <= byte_in[7:6];
                byte_cnt <= byte_in[5:3];
                counted  <= |byte_in[5:3];
            end

            if (load_addr) begin
                reg_addr <= byte_in;
                rd_req   <= byte_in[0] ? mode[0] : mode[0];
            end

            // Write strobe carries the address of the byte just received;
            // the address advances one cycle later.
            if (data_end) begin
                byte_done <= 1'b1;
                if (mode[1]) begin
                    reg_wdata <= byte_in;
                    reg_we    <= 1'b1;
                end
            end

            if (byte_done) begin
                reg_addr <= reg_addr + 8'd1;
                if (counted) byte_cnt <= byte_cnt - 3'd1;
                rd_req <= mode[0] && (state_n == DATA);
            end

            if (rd_req && (state == DATA) && !csb_s) reg_re <= 1'b1;

            // Load read data ahead of the next SCK fall, then shift MSB first.
            if (state == DATA) begin
                if (re_d) begin
                    out_shift  <= reg_rdata;
                    spi_sdo_oe <= 1'b1;
                end else if (sck_fall) begin
                    spi_sdo   <= out_shift[7];
                    out_shift <= {out_shift[6:0], 1'b0};
                end
            end

            if (state_n != DATA) begin
                spi_sdo    <= 1'b0;
                spi_sdo_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hk_spi_responder.sv
// Directed testbench for hk_spi_responder: drives SPI transfers bit by bit,
// logs register strobes and compares them with hand-computed expectations.
module tb_hk_spi_responder;

    localparam int HALF = 8;  // SCK half period in clk cycles

    logic       clk = 1'b0;
    logic       resetn;
    logic       spi_sck, spi_csb, spi_sdi;
    logic       spi_sdo, spi_sdo_oe;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       reg_we, reg_re, busy;

    logic [7:0] mem [256];

    logic [7:0] we_a[$];
    logic [7:0] we_d[$];
    logic [7:0] re_a[$];
    logic       ev[$];      // 1 = write, 0 = read, in order of occurrence

    int checks = 0;
    int errors = 0;
    int viol   = 0;
    logic prev_we = 1'b0, prev_re = 1'b0;

    hk_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .spi_sck    (spi_sck),
        .spi_csb    (spi_csb),
        .spi_sdi    (spi_sdi),
        .spi_sdo    (spi_sdo),
        .spi_sdo_oe (spi_sdo_oe),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Register file model: read data valid the cycle after reg_re.
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    // Strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (reg_we) begin
            we_a.push_back(reg_addr);
            we_d.push_back(reg_wdata);
            ev.push_back(1'b1);
        end
        if (reg_re) begin
            re_a.push_back(reg_addr);
            ev.push_back(1'b0);
        end
        if ((reg_we && reg_re) || (reg_we && prev_we) || (reg_re && prev_re)) viol++;
        prev_we = reg_we;
        prev_re = reg_re;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        we_a.delete();
        we_d.delete();
        re_a.delete();
        ev.delete();
    endtask

    // Shift out the top nbits of tx; capture SDO and OE just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic oe_all, output logic oe_any);
        rx     = '0;
        oe_all = 1'b1;
        oe_any = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = tx[7-i];
            wait_clks(HALF);
            rx[7-i] = spi_sdo;
            oe_all  = oe_all & spi_sdo_oe;
            oe_any  = oe_any | spi_sdo_oe;
            spi_sck = 1'b1;
            wait_clks(HALF);
            spi_sck = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx);
        logic [7:0] rx;
        logic       a, o;
        spi_bits(tx, 8, rx, a, o);
    endtask

    task automatic cs_start();
        spi_csb = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic cs_stop();
        wait_clks(HALF);
        spi_csb = 1'b1;
        wait_clks(HALF + 4);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sdo"},   {31'd0, spi_sdo},    32'd0);
        check({tag, "_oe"},    {31'd0, spi_sdo_oe}, 32'd0);
        check({tag, "_addr"},  {24'd0, reg_addr},   32'd0);
        check({tag, "_wdata"}, {24'd0, reg_wdata},  32'd0);
        check({tag, "_we_re"}, {30'd0, reg_we, reg_re}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},       32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        logic       oe_all, oe_any;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h05] = 8'hA5;
        mem[8'h10] = 8'h3C;

        resetn  = 1'b0;
        spi_sck = 1'b0;
        spi_csb = 1'b1;
        spi_sdi = 1'b0;
        wait_clks(4);
        check_idle_outputs("reset");
        resetn = 1'b1;
        wait_clks(10);

        // Single write.
        clear_logs();
        cs_start();
        check("busy_active", {31'd0, busy}, 32'd1);
        spi_byte(8'h80); spi_byte(8'h13); spi_byte(8'h66);
        cs_stop();
        check("sw_busy_after", {31'd0, busy}, 32'd0);
        check("sw_we_count", we_a.size(), 1);
        check("sw_addr", {24'd0, we_a[0]}, 32'h13);
        check("sw_data", {24'd0, we_d[0]}, 32'h66);
        check("sw_re_count", re_a.size(), 0);

        // Stream write across the 0xFF -> 0x00 wrap.
        clear_logs();
        cs_start();
        spi_byte(8'h80); spi_byte(8'hFE); spi_byte(8'h11); spi_byte(8'h22); spi_byte(8'h33);
        cs_stop();
        check("wrap_we_count", we_a.size(), 3);
        check("wrap_0", {we_a[0], we_d[0]}, 32'hFE11);
        check("wrap_1", {we_a[1], we_d[1]}, 32'hFF22);
        check("wrap_2", {we_a[2], we_d[2]}, 32'h0033);

        // Read with one dummy byte.
        clear_logs();
        cs_start();
        spi_bits(8'h40, 8, rx, oe_all, oe_any);
        check("rd_oe_cmd", {31'd0, oe_any}, 32'd0);
        spi_bits(8'h05, 8, rx, oe_all, oe_any);
        check("rd_oe_addr", {31'd0, oe_any}, 32'd0);
        spi_bits(8'h00, 8, rx, oe_all, oe_any);
        check("rd_oe_data", {31'd0, oe_all}, 32'd1);
        check("rd_sdo", {24'd0, rx}, 32'hA5);
        cs_stop();
        check("rd_oe_after", {31'd0, spi_sdo_oe}, 32'd0);
        check("rd_first_addr", {24'd0, re_a[0]}, 32'h05);
        begin
            int n5 = 0;
            foreach (re_a[i]) if (re_a[i] == 8'h05) n5++;
            check("rd_count_at_05", n5, 1);
        end
        check("rd_we_count", we_a.size(), 0);

        // Counted write: n = 2, third data byte ignored.
        clear_logs();
        cs_start();
        spi_byte(8'h90); spi_byte(8'h20); spi_byte(8'hA1); spi_byte(8'hB2); spi_byte(8'hC3);
        cs_stop();
        check("cnt_we_count", we_a.size(), 2);
        check("cnt_0", {we_a[0], we_d[0]}, 32'h20A1);
        check("cnt_1", {we_a[1], we_d[1]}, 32'h21B2);

        // Read/write: read of 0x10 precedes the write of 0x5A to it.
        clear_logs();
        cs_start();
        spi_byte(8'hC0); spi_byte(8'h10);
        spi_bits(8'h5A, 8, rx, oe_all, oe_any);
        cs_stop();
        check("rw_sdo", {24'd0, rx}, 32'h3C);
        check("rw_ev_count_ge2", {31'd0, ev.size() >= 2}, 32'd1);
        check("rw_order", {30'd0, ev[0], ev[1]}, 32'd1);
        check("rw_re_addr", {24'd0, re_a[0]}, 32'h10);
        check("rw_we", {we_a[0], we_d[0]}, 32'h105A);

        // CSB abort after 5 bits of a data byte.
        clear_logs();
        cs_start();
        spi_byte(8'h80); spi_byte(8'h30);
        spi_bits(8'hFF, 5, rx, oe_all, oe_any);
        cs_stop();
        check("abort_we_count", we_a.size(), 0);

        // Reset mid-address, then CSB stays low: must be ignored.
        clear_logs();
        cs_start();
        spi_byte(8'h80);
        spi_bits(8'h13, 5, rx, oe_all, oe_any);
        resetn = 1'b0;
        wait_clks(3);
        check_idle_outputs("rst_mid");
        resetn = 1'b1;
        wait_clks(HALF);
        spi_byte(8'h80); spi_byte(8'h44); spi_byte(8'h77);
        check("rst_unarmed_busy", {31'd0, busy}, 32'd0);
        cs_stop();
        check("rst_no_strobes", we_a.size() + re_a.size(), 0);
        cs_start();
        spi_byte(8'h80); spi_byte(8'h42); spi_byte(8'h99);
        cs_stop();
        check("rst_rearm_count", we_a.size(), 1);
        check("rst_rearm_we", {we_a[0], we_d[0]}, 32'h4299);

        check("strobe_spacing_viol", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hk_spi_responder.md
Name: hk_spi_responder

Overview:
Housekeeping SPI responder: the slave-side decoder for the 4-wire command/address/data SPI protocol that test benches and host tools use to reach housekeeping registers (e.g. register 0x13, the GPIO bit-bang control). Pins SCK/CSB/SDI are oversampled and synchronized into the single core clock. Each decoded transfer becomes a one-cycle register read or write strobe on a simple register port. The block sits between the pad-side SPI pins and the housekeeping register file.

Parameters:
SYNC_STAGES, 2, flops in each SCK/CSB/SDI synchronizer chain (legal: 2 or 3)

Ports:
clk  input  1  core clock
resetn  input  1  reset, asynchronous assert, active-low
spi_sck  input  1  SPI clock from pad, asynchronous
spi_csb  input  1  SPI chip select from pad, active-low, asynchronous
spi_sdi  input  1  SPI serial data in
spi_sdo  output  1  SPI serial data out
spi_sdo_oe  output  1  pad output enable for SDO
reg_addr  output  8  register address for the current access
reg_wdata  output  8  write data
reg_we  output  1  one-cycle write strobe
reg_re  output  1  one-cycle read strobe
reg_rdata  input  8  read data, valid the cycle after reg_re
busy  output  1  high while CSB is (synchronized) low

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, resetn).
- Reset values: all outputs 0, FSM in IDLE, address, count and shift registers cleared.
- Synchronization: SCK, CSB and SDI each pass through SYNC_STAGES flops. SCK rise/fall are detected by comparing the last two synchronized samples.
- Sampling and driving: SDI is sampled on each detected SCK rise. SDO changes on each detected SCK fall.
- Timing contract: SCK high and low phases must each be at least SYNC_STAGES+3 clk cycles.
- Bit order: MSB first, 8 bits per byte, counted by a 3-bit bit counter.
- FSM states: IDLE, COMMAND, ADDRESS, DATA, IGNORE.
- Any CSB high (synchronized) forces IDLE from every state. Any partial byte is discarded with no strobe. spi_sdo_oe is forced to 0.
- IDLE -> COMMAND when synchronized CSB goes low. The bit counter clears.
- Command byte: bits[7:6] select the mode: 10 = write, 01 = read, 11 = read/write, 00 = no-op. Bits[5:3] = n: 0 means stream until CSB rises; 1-7 means exactly n data bytes. Bits[2:0] are ignored.
- Mode 00 goes to IGNORE (SDO not driven). Any other mode goes to ADDRESS after the 8th rise.
- Address byte: on its 8th rise, reg_addr is loaded and the FSM moves to DATA.
- Read and read/write: reg_re pulses on the clk after reg_addr loads.
- Read data path: reg_rdata is captured into the output shift register the following clk, and spi_sdo_oe is set to 1.
- SDO output: the next SCK fall presents bit7 on spi_sdo. Each later fall shifts one bit.
- DATA, write modes: on the 8th rise, reg_wdata is loaded and reg_we pulses for exactly one clk with the current reg_addr.
- DATA, read/write: the read of an address (reg_re) always precedes the write to that address.
- Byte completion: after each data byte, reg_addr increments modulo 256 (0xFF wraps to 0x00).
- Next read: in read modes, a new reg_re issues for the new address, in time for its MSB at the next SCK fall.
- Byte count: when n != 0, the byte counter decrements per completed data byte. At 0 the FSM goes to IGNORE: no further strobes, SDO not driven, wait for CSB high.
- Strobe spacing: reg_we and reg_re are never asserted in the same cycle and never for more than one clk.
- busy: follows synchronized CSB low.
- resetn low mid-transfer: immediate return to reset values. After release, the block waits for a fresh CSB falling edge; a CSB already low is ignored until it goes high.

Test Plan:
- Single write: CSB low, bytes 0x80, 0x13, 0x66, CSB high -> exactly one reg_we with reg_addr=0x13 and reg_wdata=0x66; reg_re never pulses.
- Stream write with wrap: bytes 0x80, 0xFE, 0x11, 0x22, 0x33 -> reg_we at addr 0xFE/0x11, 0xFF/0x22, 0x00/0x33.
- Read: bytes 0x40, 0x05, then one dummy byte, with reg_rdata=0xA5 -> one reg_re at 0x05; spi_sdo shifts 1,0,1,0,0,1,0,1; spi_sdo_oe is 0 during the command and address bytes and 1 during data.
- Counted write: 0x90 (write, n=2), addr 0x20, then 3 data bytes -> writes only to 0x20 and 0x21; the third byte is ignored.
- Read/write: 0xC0, addr 0x10, data 0x5A with reg_rdata=0x3C -> SDO returns 0x3C; reg_re precedes reg_we(0x10, 0x5A).
- Aborts: CSB raised after 5 bits of a data byte -> no reg_we. resetn pulsed low mid-address -> all outputs 0; no strobes until CSB toggles high then low.
